sc_datamem_io_gen: RTL and testbench

//  Parametrised data memory with memory-mapped I/O for the single-cycle CPU.
//  - Addresses with addr[IO_BIT]=0 access a word RAM.
//  - Addresses with addr[IO_BIT]=1 access N_OUT output registers, N_IN synchronised inputs,
//    a sticky input-change status register and an IRQ mask.
//  - Adds byte enables, atomic SET/CLR on outputs, a registered read with valid, and a change IRQ.

---
 rtl/sc_datamem_io_gen_pkg.sv | 30 +++
 rtl/sc_datamem_io_gen_if.sv | 17 +
 rtl/sc_datamem_io_gen_sync.sv | 31 +++
 rtl/sc_datamem_io_gen.sv | 163 ++++++++++++++++
 tb/tb_sc_datamem_io_gen.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/sc_datamem_io_gen_pkg.sv
// Shared constants and helpers for the data memory / memory-mapped I/O block.
package sc_datamem_io_gen_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int RAM_AW_DEF = 5;
  localparam int IO_BIT_DEF = 7;
  localparam int N_IN_DEF   = 4;
  localparam int N_OUT_DEF  = 4;

  localparam logic [1:0] OP_OUT   = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLR   = 2'b10;
  localparam logic [1:0] OP_INCTL = 2'b11;

  // Widest data path byte_merge supports; callers zero-extend and take the low bits.
  localparam int MAX_W  = 256;
  localparam int MAX_BE = MAX_W / 8;

  function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0] old_v,
                                                  input logic [MAX_W-1:0] new_v,
                                                  input logic [MAX_BE-1:0] be_v);
    logic [MAX_W-1:0] res;
    res = old_v;
    for (int k = 0; k < MAX_BE; k++) begin
      res[8*k +: 8] = be_v[k] ? new_v[8*k +: 8] : old_v[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sc_datamem_io_gen_if.sv
// CPU-side load/store bus of the data memory.
interface sc_datamem_io_gen_if
  import sc_datamem_io_gen_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic [31:0]         addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] be;
  logic                we;
  logic                re;
  logic [DATA_W-1:0]   rdata;
  logic                rvalid;

  modport master (output addr, wdata, be, we, re, input rdata, rvalid);
  modport slave  (input addr, wdata, be, we, re, output rdata, rvalid);
endinterface

// File: rtl/sc_datamem_io_gen_sync.sv
// Two-flop synchroniser for one input port plus a previous-value register for change detection.
module sc_datamem_io_gen_sync
  import sc_datamem_io_gen_pkg::*;
#(
  parameter int W = DATA_W_DEF
) (
  input  logic         clock,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] sync,
  output logic         chg
);
  logic [W-1:0] meta_r;
  logic [W-1:0] sync_r;
  logic [W-1:0] prev_r;

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      meta_r <= '0;
      sync_r <= '0;
      prev_r <= '0;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign sync = sync_r;
  assign chg  = (sync_r != prev_r);
endmodule

// File: rtl/sc_datamem_io_gen.sv
// Word RAM plus memory-mapped output/input/status/mask registers with a registered read port
// and an input-change interrupt.
module sc_datamem_io_gen
  import sc_datamem_io_gen_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RAM_AW = RAM_AW_DEF,
  parameter int IO_BIT = IO_BIT_DEF,
  parameter int N_IN   = N_IN_DEF,
  parameter int N_OUT  = N_OUT_DEF,
  parameter logic [DATA_W-1:0] OUT_RST = {DATA_W{1'b0}}
) (
  input  logic                    clock,
  input  logic                    clr,
  sc_datamem_io_gen_if.slave      bus,
  input  logic [N_IN*DATA_W-1:0]  in_port,
  output logic [N_OUT*DATA_W-1:0] out_port,
  output logic                    irq
);
  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = IO_BIT - 4;

  logic [DATA_W-1:0] ram_r [2**RAM_AW];
  logic [DATA_W-1:0] out_r [N_OUT];
  logic [DATA_W-1:0] out_next_s [N_OUT];
  logic [DATA_W-1:0] sync_s [N_IN];
  logic [N_IN-1:0]   chg_s;
  logic [N_IN-1:0]   status_r;
  logic [N_IN-1:0]   status_clr_s;
  logic [N_IN-1:0]   mask_r;
  logic [N_IN-1:0]   mask_next_s;
  logic [DATA_W-1:0] rdata_r;
  logic              rvalid_r;
  logic [DATA_W-1:0] rd_mux_s;
  logic [DATA_W-1:0] wr_bits_s;
  logic [DATA_W-1:0] mask_mrg_s;

  logic              is_io_s;
  logic [RAM_AW-1:0] ram_idx_s;
  logic [1:0]        op_s;
  logic [IDX_W-1:0]  idx_s;
  logic [31:0]       idx_n_s;
  logic              io_wr_s;
  logic              ram_we_s;
  logic              unused_s;

  function automatic logic [DATA_W-1:0] merge_w(input logic [DATA_W-1:0] old_v,
                                                input logic [DATA_W-1:0] new_v,
                                                input logic [BE_W-1:0]   be_v);
    logic [MAX_W-1:0] m;
    m = byte_merge(MAX_W'(old_v), MAX_W'(new_v), MAX_BE'(be_v));
    return m[DATA_W-1:0];
  endfunction

  assign is_io_s   = bus.addr[IO_BIT];
  assign ram_idx_s = bus.addr[RAM_AW+1:2];
  assign op_s      = bus.addr[IO_BIT-1 -: 2];
  assign idx_s     = bus.addr[IO_BIT-3:2];
  assign idx_n_s   = 32'(idx_s);
  assign io_wr_s   = bus.we & is_io_s;
  // clr is gated in so an access that overlaps reset never lands in the unreset RAM.
  assign ram_we_s  = bus.we & ~is_io_s & ~clr;
  assign unused_s  = ^{bus.addr[31:IO_BIT+1], bus.addr[1:0]};

  assign wr_bits_s  = merge_w({DATA_W{1'b0}}, bus.wdata, bus.be);
  assign mask_mrg_s = merge_w(DATA_W'(mask_r), bus.wdata, bus.be);

  for (genvar g = 0; g < N_IN; g++) begin : g_in
    sc_datamem_io_gen_sync #(.W(DATA_W)) u_sync (
      .clock (clock),
      .clr   (clr),
      .din   (in_port[g*DATA_W +: DATA_W]),
      .sync  (sync_s[g]),
      .chg   (chg_s[g])
    );
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_out
    assign out_port[g*DATA_W +: DATA_W] = out_r[g];
  end

  always_ff @(posedge clock) begin
    if (ram_we_s) begin
      ram_r[ram_idx_s] <= merge_w(ram_r[ram_idx_s], bus.wdata, bus.be);
    end else begin
      ram_r[ram_idx_s] <= ram_r[ram_idx_s];
    end
  end

  always_comb begin
    status_clr_s = '0;
    mask_next_s  = mask_r;
    for (int i = 0; i < N_OUT; i++) begin
      out_next_s[i] = out_r[i];
      if (io_wr_s && (op_s != OP_INCTL) && (idx_n_s == 32'(i))) begin
        case (op_s)
          OP_OUT:  out_next_s[i] = merge_w(out_r[i], bus.wdata, bus.be);
          OP_SET:  out_next_s[i] = merge_w(out_r[i], out_r[i] | bus.wdata, bus.be);
          OP_CLR:  out_next_s[i] = merge_w(out_r[i], out_r[i] & ~bus.wdata, bus.be);
          default: out_next_s[i] = out_r[i];
        endcase
      end else begin
        out_next_s[i] = out_r[i];
      end
    end
    if (io_wr_s && (op_s == OP_INCTL) && (idx_n_s == 32'(N_IN))) begin
      status_clr_s = wr_bits_s[N_IN-1:0];
    end else if (io_wr_s && (op_s == OP_INCTL) && (idx_n_s == 32'(N_IN + 1))) begin
      mask_next_s = mask_mrg_s[N_IN-1:0];
    end else begin
      mask_next_s = mask_r;
    end
  end

  // Read path sees pre-edge state, giving read-first behaviour for RAM and registers.
  always_comb begin
    rd_mux_s = '0;
    if (!is_io_s) begin
      rd_mux_s = ram_r[ram_idx_s];
    end else begin
      case (op_s)
        OP_OUT: begin
          for (int i = 0; i < N_OUT; i++) begin
            rd_mux_s = rd_mux_s | (out_r[i] & {DATA_W{idx_n_s == 32'(i)}});
          end
        end
        OP_INCTL: begin
          for (int i = 0; i < N_IN; i++) begin
            rd_mux_s = rd_mux_s | (sync_s[i] & {DATA_W{idx_n_s == 32'(i)}});
          end
          rd_mux_s = rd_mux_s | (DATA_W'(status_r) & {DATA_W{idx_n_s == 32'(N_IN)}});
          rd_mux_s = rd_mux_s | (DATA_W'(mask_r) & {DATA_W{idx_n_s == 32'(N_IN + 1)}});
        end
        default: rd_mux_s = '0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < N_OUT; i++) begin
        out_r[i] <= OUT_RST;
      end
      status_r <= '0;
      mask_r   <= '0;
      rdata_r  <= '0;
      rvalid_r <= 1'b0;
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        out_r[i] <= out_next_s[i];
      end
      // A new change detection takes priority over a same-edge W1C.
      status_r <= (status_r & ~status_clr_s) | chg_s;
      mask_r   <= mask_next_s;
      rdata_r  <= bus.re ? rd_mux_s : rdata_r;
      rvalid_r <= bus.re;
    end
  end

  assign bus.rdata  = rdata_r;
  assign bus.rvalid = rvalid_r;
  assign irq        = |(status_r & mask_r);
endmodule

// File: tb/tb_sc_datamem_io_gen.sv
// Directed bench for sc_datamem_io_gen: read results are scoreboarded against a queue of expectations.
module tb_sc_datamem_io_gen;
  localparam int DW = 32;

  logic           clock;
  logic           clr;
  logic [4*DW-1:0] in_port;
  logic [4*DW-1:0] out_port;
  logic           irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  sc_datamem_io_gen_if #(.DATA_W(DW)) bus ();

  sc_datamem_io_gen dut (
    .clock    (clock),
    .clr      (clr),
    .bus      (bus),
    .in_port  (in_port),
    .out_port (out_port),
    .irq      (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    bus.addr = a; bus.wdata = d; bus.be = b; bus.we = 1'b1; bus.re = 1'b0;
    cyc();
    bus.we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    bus.addr = a; bus.re = 1'b1; bus.we = 1'b0;
    exp_q.push_back(exp); tag_q.push_back(tag);
    cyc();
    bus.re = 1'b0;
  endtask

  task automatic rw(input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp, input string tag);
    bus.addr = a; bus.wdata = d; bus.be = 4'hF; bus.we = 1'b1; bus.re = 1'b1;
    exp_q.push_back(exp); tag_q.push_back(tag);
    cyc();
    bus.we = 1'b0; bus.re = 1'b0;
  endtask

  // Scoreboard: every rvalid must match the oldest outstanding read.
  always @(negedge clock) begin
    if (bus.rvalid === 1'b1) begin
      int n;
      logic [31:0] e;
      string t;
      n = exp_q.size();
      checks++;
      assert (n != 0) else begin
        errors++;
        $error("FAIL spurious_rvalid: observed rvalid=1 expected no outstanding read");
      end
      if (n != 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (bus.rdata === e) else begin
          errors++;
          $error("FAIL %s: observed %h expected %h", t, bus.rdata, e);
        end
      end
    end
  end

  initial begin
    clr = 1'b0; in_port = '0;
    bus.addr = 32'h0; bus.wdata = 32'h0; bus.be = 4'h0; bus.we = 1'b0; bus.re = 1'b0;
    #1 clr = 1'b1;
    cyc(); cyc();
    chk("rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_out0", out_port[0 +: 32], 32'h0);
    chk("rst_out3", out_port[96 +: 32], 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    clr = 1'b0;
    cyc();

    // RAM full-word and byte-lane writes
    wr(32'h04, 32'hDEADBEEF, 4'hF);
    rd(32'h04, 32'hDEADBEEF, "ram_word");
    cyc();
    chk("rdata_hold", bus.rdata, 32'hDEADBEEF);
    chk("rvalid_idle", {31'd0, bus.rvalid}, 32'd0);
    wr(32'h04, 32'h000000AA, 4'h1);
    rd(32'h04, 32'hDEADBEAA, "ram_byte");
    wr(32'h08, 32'hDEADBEEF, 4'hF);
    rw(32'h08, 32'h12345678, 32'hDEADBEEF, "ram_read_first");
    rd(32'h08, 32'h12345678, "ram_after_rw");
    wr(32'h10, 32'h600DF00D, 4'hF);

    // Output bank: OUT / SET / CLR
    wr(32'h80, 32'h00000F0F, 4'hF);
    chk("out0_write", out_port[0 +: 32], 32'h00000F0F);
    wr(32'hA0, 32'h0000F000, 4'hF);
    chk("out0_set", out_port[0 +: 32], 32'h0000FF0F);
    wr(32'hC0, 32'h0000000F, 4'hF);
    chk("out0_clr", out_port[0 +: 32], 32'h0000FF00);
    rd(32'hA0, 32'h0, "set_reads_zero");
    rd(32'hC0, 32'h0, "clr_reads_zero");
    wr(32'hA0, 32'hFFFFFFFF, 4'b0100);
    chk("out0_set_be", out_port[0 +: 32], 32'h00FFFF00);
    rw(32'h80, 32'h11111111, 32'h00FFFF00, "out_read_first");
    chk("out0_after_rw", out_port[0 +: 32], 32'h11111111);
    chk("out1_untouched", out_port[32 +: 32], 32'h0);
    wr(32'h84, 32'h12345678, 4'hF);
    chk("out1_write", out_port[32 +: 32], 32'h12345678);

    // Mask keeps only N_IN bits
    wr(32'hF4, 32'hFFFFFFFF, 4'hF);
    rd(32'hF4, 32'h0000000F, "mask_width");
    wr(32'hF4, 32'h00000004, 4'hF);

    // Input 2: synchroniser and change-status latency
    in_port[64 +: 32] = 32'h55;
    rd(32'hE8, 32'h0, "in2_t1");
    chk("irq_t1", {31'd0, irq}, 32'd0);
    cyc();
    chk("irq_t2", {31'd0, irq}, 32'd0);
    rd(32'hE8, 32'h55, "in2_synced");
    chk("irq_t3", {31'd0, irq}, 32'd1);
    rd(32'hF0, 32'h4, "status_bit2");
    wr(32'hF0, 32'h4, 4'h0);
    chk("w1c_be0_keeps", {31'd0, irq}, 32'd1);
    wr(32'hF0, 32'h4, 4'hF);
    chk("w1c_irq_low", {31'd0, irq}, 32'd0);
    rd(32'hF0, 32'h0, "status_cleared");

    // Change detect beats a same-edge W1C
    in_port[32 +: 32] = 32'h1;
    cyc(); cyc();
    wr(32'hF0, 32'h2, 4'hF);
    rd(32'hF0, 32'h2, "set_wins");
    wr(32'hF0, 32'h2, 4'hF);
    rd(32'hF0, 32'h0, "status_w1c_b1");

    // Reset in the middle of an OUT1 write with a read pending
    in_port = '0;
    cyc(); cyc(); cyc();
    bus.addr = 32'h84; bus.wdata = 32'hCAFEF00D; bus.be = 4'hF; bus.we = 1'b1; bus.re = 1'b1;
    #2 clr = 1'b1;
    @(posedge clock); #1;
    bus.we = 1'b0; bus.re = 1'b0;
    chk("rst_mid_out1", out_port[32 +: 32], 32'h0);
    chk("rst_mid_out0", out_port[0 +: 32], 32'h0);
    chk("rst_mid_rvalid", {31'd0, bus.rvalid}, 32'd0);
    chk("rst_mid_irq", {31'd0, irq}, 32'd0);
    clr = 1'b0;
    cyc();
    rd(32'hF0, 32'h0, "rst_status");
    rd(32'hF4, 32'h0, "rst_mask");
    rd(32'h84, 32'h0, "rst_out1_rd");
    rd(32'h04, 32'hDEADBEAA, "ram_survives_rst");

    // Out-of-range indices
    wr(32'h90, 32'hFFFFFFFF, 4'hF);
    wr(32'hF8, 32'hFFFFFFFF, 4'hF);
    chk("oor_out0", out_port[0 +: 32], 32'h0);
    chk("oor_out3", out_port[96 +: 32], 32'h0);
    rd(32'h90, 32'h0, "oor_out_rd");
    rd(32'hF8, 32'h0, "oor_ctl_rd");
    rd(32'hF4, 32'h0, "oor_mask_same");
    rd(32'h10, 32'h600DF00D, "io_not_ram");

    cyc(); cyc();
    chk("pending_reads", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
